stream_mux_nto1: RTL and testbench
==================================

// Module: stream_mux_nto1
// PURPOSE
//  Registered N-input, W-bit stream multiplexer with valid/ready handshake and packet lock.
//  Successor to the combinational 2:1 bit-slice mux: generalised width and channel count.
//  Locks the chosen input for a whole packet and drives a single output through one register stage.
//  Sits between channel producers and a shared downstream consumer (ALU/bus port).
// PARAMETERS
//  W      8   data width per channel (>=1)
//  N      4   number of input channels (>=2)
//  SELW   localparam = (N>1) ? $clog2(N) : 1; width of sel/out_chan
// PORTS
//  clk       in   1        rising-edge clock; the block's only clock
//  rst_n     in   1        asynchronous, active-low reset
//  in_data   in   N*W      channel k data on bits [k*W +: W]
//  in_valid  in   N        channel k has a beat
//  in_last   in   N        channel k beat is the last of its packet
//  in_ready  out  N        channel k beat accepted when in_valid[k] && in_ready[k]
//  sel       in   SELW     external channel select; used only without MUX_RR_ARB_EN
//  out_data  out  W        registered output data
//  out_valid out  1        output beat present
//  out_last  out  1        registered copy of accepted in_last
//  out_chan  out  SELW     channel index of the current output beat
//  out_ready in   1        consumer accepts when out_valid && out_ready
//  busy      out  1        1 while in LOCK
// BEHAVIOUR
//  - Reset values: in_ready=0, out_valid=0, out_data=0, out_last=0, out_chan=0, busy=0, state=IDLE, rr_ptr=0.
//  - FSM IDLE: candidate chosen (see CONFIGURATION); if candidate valid, cur<=candidate, go LOCK next edge.
//    No beat is accepted in IDLE: one bubble cycle per packet.
//  - FSM LOCK: in_ready[cur] = !out_valid || out_ready; all other in_ready bits are 0.
//    Accepted beat loads out_data/out_last/out_chan on that edge: latency 1 cycle.
//    Accepted beat with in_last=1 -> IDLE on the same edge.
//  - Output register: out_valid cleared on out_ready when no new beat loads.
//    Simultaneous drain and load keeps out_valid=1 for full throughput.
//    Output holds stable while out_valid && !out_ready.
//  - sel changes during LOCK are ignored.
//  - Out-of-range sel (>=N, N not a power of 2): no grant; stay IDLE.
//  - in_valid dropping mid-packet: stay LOCK and wait; no timeout.
//  - rst_n low mid-packet: immediate abort; the output beat is discarded; every output returns to its reset value.
//  - out_data is the exact W-bit slice; no width conversion.
// CONFIGURATION
//  Macro MUX_RR_ARB_EN:
//  - Defined: sel is ignored and the round-robin arbiter is used.
//    The arbiter searches channels rr_ptr, rr_ptr+1, ... mod N and takes the first with in_valid=1.
//    On packet end (last beat accepted), rr_ptr <= (cur+1) mod N.
//  - Undefined: candidate = sel; grant only if in_valid[sel]=1; rr_ptr logic absent.
// STRUCTURE
//  - Shared package stream_mux_pkg:
//    typedef enum logic {ST_IDLE, ST_LOCK} mux_state_t; function clog2_safe.
//  - Sub-module rr_arbiter_n (N, SELW): in req[N], ptr -> gnt_idx, gnt_vld.
//    Instantiated only under MUX_RR_ARB_EN.
//  - Data path: indexed part-select in_data[cur*W +: W]; no per-bit mux instances.
// TESTING
//  1 Reset: assert rst_n=0 mid-run -> all outputs 0 same cycle; after release busy=0, in_ready=0.
//  2 sel=2, in_valid[2]=1, 3 beats 0xA1,0xA2,0xA3 (last on 0xA3), out_ready=1.
//    -> busy at cycle 1; out_data A1/A2/A3 on cycles 2-4, out_chan=2, out_last only with A3.
//  3 Backpressure: out_ready=0 for 3 cycles mid-packet -> out_data held, in_ready[cur]=0.
//    Release -> no beat lost or duplicated.
//  4 sel switched 2->0 during a packet -> stream stays on ch2 until last; ch0 granted after IDLE bubble.
//  5 N=3, sel=3 with all valid -> no grant, in_ready=0, busy=0 for 10 cycles.
//  6 MUX_RR_ARB_EN, all 4 channels continuously valid, 1-beat packets -> grant order 0,1,2,3,0.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the N:1 stream multiplexer family.
package stream_mux_pkg;

   typedef enum logic {ST_IDLE, ST_LOCK} mux_state_t;

   // Index width that stays at least 1 bit for degenerate channel counts.
   function automatic int clog2_safe(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/stream_mux_nto1_rr_arbiter.sv
// Round-robin picker: first requesting channel at or after ptr, wrapping mod N.
module rr_arbiter_n
   import stream_mux_pkg::*;
#(
   parameter int N    = 4,
   parameter int SELW = clog2_safe(N)
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   output logic [SELW-1:0] gnt_idx,
   output logic            gnt_vld
);

   int unsigned idx;

   always_comb begin
      gnt_idx = '0;
      gnt_vld = 1'b0;
      idx     = 0;
      for (int unsigned i = 0; i < unsigned'(N); i++) begin
         idx = (unsigned'(int'(ptr)) + i) % unsigned'(N);
         if (!gnt_vld && req[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = SELW'(idx);
         end
      end
   end

endmodule

// File: rtl/stream_mux_nto1.sv
// Registered N:1 stream mux with packet lock; define MUX_RR_ARB_EN to replace
// the external sel with an internal round-robin arbiter.
module stream_mux_nto1
   import stream_mux_pkg::*;
#(
   parameter int W = 8,
   parameter int N = 4,
   localparam int SELW = clog2_safe(N)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N*W-1:0]    in_data,
   input  logic [N-1:0]      in_valid,
   input  logic [N-1:0]      in_last,
   output logic [N-1:0]      in_ready,
   input  logic [SELW-1:0]   sel,
   output logic [W-1:0]      out_data,
   output logic              out_valid,
   output logic              out_last,
   output logic [SELW-1:0]   out_chan,
   input  logic              out_ready,
   output logic              busy
);

   mux_state_t      state, state_nxt;
   logic [SELW-1:0] cur, cur_nxt;
   logic [SELW-1:0] cand;
   logic            cand_vld;
   logic            load;
   logic            pkt_end;

`ifdef MUX_RR_ARB_EN
   logic [SELW-1:0] rr_ptr;
   logic            unused_sel;

   assign unused_sel = ^sel;

   rr_arbiter_n #(
      .N    (N),
      .SELW (SELW)
   ) u_arb (
      .req     (in_valid),
      .ptr     (rr_ptr),
      .gnt_idx (cand),
      .gnt_vld (cand_vld)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (pkt_end) begin
         rr_ptr <= (cur == SELW'(N - 1)) ? '0 : cur + 1'b1;
      end
   end
`else
   logic sel_in_range;

   // A full power-of-two sel space can never point past the last channel.
   if ((1 << SELW) == N) begin : g_sel_full
      assign sel_in_range = 1'b1;
   end else begin : g_sel_part
      assign sel_in_range = (int'(sel) < N);
   end

   assign cand     = sel;
   assign cand_vld = sel_in_range && in_valid[sel];
`endif

   always_comb begin
      state_nxt = state;
      cur_nxt   = cur;
      in_ready  = '0;
      load      = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (cand_vld) begin
               cur_nxt   = cand;
               state_nxt = ST_LOCK;
            end
         end
         ST_LOCK: begin
            in_ready[cur] = !out_valid || out_ready;
            load          = in_valid[cur] && in_ready[cur];
            if (load && in_last[cur]) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign pkt_end = load && in_last[cur];
   assign busy    = (state == ST_LOCK);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cur   <= '0;
      end else begin
         state <= state_nxt;
         cur   <= cur_nxt;
      end
   end

   // A load wins over a drain so back-to-back beats keep out_valid high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_chan  <= '0;
      end else if (load) begin
         out_data  <= in_data[cur*W +: W];
         out_valid <= 1'b1;
         out_last  <= in_last[cur];
         out_chan  <= cur;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_stream_mux_nto1.sv
// Self-checking bench for stream_mux_nto1: vector table, corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_stream_mux_nto1;

   localparam int W = 8;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [31:0]  in_data;
   logic [3:0]   in_valid, in_last, in_ready;
   logic [1:0]   sel;
   logic [7:0]   out_data;
   logic         out_valid, out_last, out_ready, busy;
   logic [1:0]   out_chan;

   // Three-channel instance for the out-of-range select case.
   logic [23:0]  in_data3;
   logic [2:0]   in_valid3, in_last3, in_ready3;
   logic [1:0]   sel3, out_chan3;
   logic [7:0]   out_data3;
   logic         out_valid3, out_last3, out_ready3, busy3;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   stream_mux_nto1 #(.W(W), .N(N)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_last(in_last), .in_ready(in_ready), .sel(sel), .out_data(out_data),
      .out_valid(out_valid), .out_last(out_last), .out_chan(out_chan),
      .out_ready(out_ready), .busy(busy)
   );

   stream_mux_nto1 #(.W(8), .N(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
      .in_last(in_last3), .in_ready(in_ready3), .sel(sel3), .out_data(out_data3),
      .out_valid(out_valid3), .out_last(out_last3), .out_chan(out_chan3),
      .out_ready(out_ready3), .busy(busy3)
   );

   typedef struct {
      logic [1:0] sel;  logic [3:0] vld; logic [3:0] lst; logic [7:0] d; logic ordy;
      logic       busy; logic [3:0] ird; logic ov; logic [7:0] od; logic ol; logic [1:0] oc;
   } vec_t;

   vec_t tbl [14];

   function automatic vec_t mk(input logic [1:0] s, input logic [3:0] v, input logic [3:0] l,
                               input logic [7:0] d, input logic r, input logic b,
                               input logic [3:0] ir, input logic ov, input logic [7:0] od,
                               input logic ol, input logic [1:0] oc);
      vec_t t;
      t.sel = s; t.vld = v; t.lst = l; t.d = d; t.ordy = r;
      t.busy = b; t.ird = ir; t.ov = ov; t.od = od; t.ol = ol; t.oc = oc;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [1:0] s, input logic [3:0] v, input logic [3:0] l,
                        input logic [7:0] d, input logic r);
      sel = s; in_valid = v; in_last = l; in_data = {4{d}}; out_ready = r;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Reference model state: lock flag, locked channel, output register, rr pointer.
   bit       m_lock;
   int       m_ch, m_rr;
   bit       m_ov, m_ol;
   bit [7:0] m_od;
   int       m_oc;

   task automatic model_reset();
      m_lock = 0; m_ch = 0; m_rr = 0; m_ov = 0; m_ol = 0; m_od = '0; m_oc = 0;
   endtask

   function automatic logic [3:0] model_ready();
      logic [3:0] r = '0;
      if (m_lock && (!m_ov || out_ready)) r[m_ch] = 1'b1;
      return r;
   endfunction

   task automatic model_step();
      bit acc;
      int c;
      acc = m_lock && in_valid[m_ch] && (!m_ov || out_ready);
      if (acc) begin
         m_ov = 1; m_od = in_data[m_ch*8 +: 8]; m_ol = in_last[m_ch]; m_oc = m_ch;
      end else if (out_ready) begin
         m_ov = 0;
      end
      if (!m_lock) begin
         c = -1;
`ifdef MUX_RR_ARB_EN
         for (int k = 0; k < N; k++)
            if (c < 0 && in_valid[(m_rr + k) % N]) c = (m_rr + k) % N;
`else
         if (int'(sel) < N && in_valid[sel]) c = int'(sel);
`endif
         if (c >= 0) begin
            m_lock = 1; m_ch = c;
         end
      end else if (acc && in_last[m_ch]) begin
         m_lock = 0;
         m_rr   = (m_ch + 1) % N;
      end
   endtask

   initial begin
      int       n;
      logic [1:0] rr_exp [5];

      tbl[0]  = mk(2, 4'b0100, 4'b0000, 8'hA1, 1, 0, 4'b0000, 0, 8'h00, 0, 0);
      tbl[1]  = mk(2, 4'b0100, 4'b0000, 8'hA1, 1, 1, 4'b0100, 0, 8'h00, 0, 0);
      tbl[2]  = mk(2, 4'b0100, 4'b0000, 8'hA2, 1, 1, 4'b0100, 1, 8'hA1, 0, 2);
      tbl[3]  = mk(2, 4'b0100, 4'b0100, 8'hA3, 1, 1, 4'b0100, 1, 8'hA2, 0, 2);
      tbl[4]  = mk(2, 4'b0000, 4'b0000, 8'h00, 1, 0, 4'b0000, 1, 8'hA3, 1, 2);
      tbl[5]  = mk(2, 4'b0000, 4'b0000, 8'h00, 1, 0, 4'b0000, 0, 8'hA3, 1, 2);
      tbl[6]  = mk(1, 4'b0010, 4'b0000, 8'hB1, 1, 0, 4'b0000, 0, 8'hA3, 1, 2);
      tbl[7]  = mk(1, 4'b0010, 4'b0000, 8'hB1, 1, 1, 4'b0010, 0, 8'hA3, 1, 2);
      tbl[8]  = mk(1, 4'b0010, 4'b0000, 8'hB2, 0, 1, 4'b0000, 1, 8'hB1, 0, 1);
      tbl[9]  = mk(1, 4'b0010, 4'b0000, 8'hB2, 0, 1, 4'b0000, 1, 8'hB1, 0, 1);
      tbl[10] = mk(1, 4'b0010, 4'b0000, 8'hB2, 0, 1, 4'b0000, 1, 8'hB1, 0, 1);
      tbl[11] = mk(1, 4'b0010, 4'b0010, 8'hB2, 1, 1, 4'b0010, 1, 8'hB1, 0, 1);
      tbl[12] = mk(1, 4'b0000, 4'b0000, 8'h00, 1, 0, 4'b0000, 1, 8'hB2, 1, 1);
      tbl[13] = mk(1, 4'b0000, 4'b0000, 8'h00, 1, 0, 4'b0000, 0, 8'hB2, 1, 1);

      rr_exp[0] = 2'd0; rr_exp[1] = 2'd1; rr_exp[2] = 2'd2; rr_exp[3] = 2'd3; rr_exp[4] = 2'd0;

      in_data3 = 24'h332211; in_valid3 = 3'b111; in_last3 = 3'b111; sel3 = 2'd3; out_ready3 = 1'b1;
      rst_n = 1'b0;
      drive(0, 4'b0000, 4'b0000, 8'h00, 1);
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_ready", in_ready, 0);
      chk("rst_oval", out_valid, 0);
      chk("rst_odata", out_data, 0);
      next_cycle();

      for (int i = 0; i < 10; i++) begin
         #2;
         chk("n3_oor_ready", in_ready3, 0);
         chk("n3_oor_busy", busy3, 0);
         chk("n3_oor_oval", out_valid3, 0);
         next_cycle();
      end

`ifndef MUX_RR_ARB_EN
      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].sel, tbl[i].vld, tbl[i].lst, tbl[i].d, tbl[i].ordy);
         #2;
         chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
         chk($sformatf("tbl%0d_ready", i), in_ready, tbl[i].ird);
         chk($sformatf("tbl%0d_oval", i), out_valid, tbl[i].ov);
         chk($sformatf("tbl%0d_odata", i), out_data, tbl[i].od);
         chk($sformatf("tbl%0d_olast", i), out_last, tbl[i].ol);
         chk($sformatf("tbl%0d_ochan", i), out_chan, tbl[i].oc);
         next_cycle();
      end

      // Select moves to channel 0 while channel 2 still owns the packet.
      drive(2, 4'b0101, 4'b0000, 8'hC1, 1);
      #2; chk("sw_idle_busy", busy, 0);
      next_cycle();
      drive(0, 4'b0101, 4'b0000, 8'hC1, 1);
      #2; chk("sw_ready_ch2", in_ready, 4'b0100);
      next_cycle();
      drive(0, 4'b0101, 4'b0100, 8'hC2, 1);
      #2; chk("sw_chan_c1", out_chan, 2); chk("sw_data_c1", out_data, 8'hC1);
      chk("sw_ready_last", in_ready, 4'b0100);
      next_cycle();
      drive(0, 4'b0001, 4'b0001, 8'hD1, 1);
      #2; chk("sw_bubble_busy", busy, 0); chk("sw_chan_c2", out_chan, 2);
      chk("sw_data_c2", out_data, 8'hC2); chk("sw_last_c2", out_last, 1);
      chk("sw_bubble_ready", in_ready, 0);
      next_cycle();
      #2; chk("sw_ch0_busy", busy, 1); chk("sw_ch0_ready", in_ready, 4'b0001);
      next_cycle();
      drive(0, 4'b0000, 4'b0000, 8'h00, 1);
      #2; chk("sw_ch0_data", out_data, 8'hD1); chk("sw_ch0_chan", out_chan, 0);
      chk("sw_ch0_last", out_last, 1); chk("sw_ch0_idle", busy, 0);
      next_cycle();
`else
      drive(0, 4'b1111, 4'b1111, 8'hF0, 1);
      n = 0;
      for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
         #2;
         if (out_valid) begin
            chk($sformatf("rr_order%0d", n), out_chan, rr_exp[n]);
            n++;
         end
         next_cycle();
      end
      if (n < 5) chk("rr_timeout", n, 5);
      drive(0, 4'b0000, 4'b0000, 8'h00, 1);
      next_cycle();
      next_cycle();
`endif

      // Abort mid-packet on channel 3 once a beat sits in the output register.
      drive(3, 4'b1000, 4'b0000, 8'hE1, 0);
      next_cycle();
      next_cycle();
      #2;
      chk("abort_pre_oval", out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("abort_odata", out_data, 0);
      chk("abort_oval", out_valid, 0);
      chk("abort_olast", out_last, 0);
      chk("abort_ochan", out_chan, 0);
      chk("abort_busy", busy, 0);
      chk("abort_ready", in_ready, 0);
      next_cycle();
      rst_n = 1'b1;
      #1;
      chk("release_busy", busy, 0);
      chk("release_ready", in_ready, 0);
      model_reset();

      for (int cyc = 0; cyc < 400; cyc++) begin
         logic [3:0] v, l;
         v = '0; l = '0;
         for (int k = 0; k < N; k++) begin
            v[k] = ($urandom_range(0, 3) != 0);
            l[k] = ($urandom_range(0, 2) == 0);
         end
         sel = 2'($urandom_range(0, 3));
         in_valid = v;
         in_last = l;
         in_data = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         #2;
         chk("rand_ready", in_ready, model_ready());
         chk("rand_busy", busy, m_lock);
         chk("rand_out", {out_valid, out_last, out_chan, out_data},
             {m_ov, m_ol, 2'(m_oc), m_od});
         model_step();
         next_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
